// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types: transfer/size/response encodings and the SRAM slave FSM states.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic [2:0] SIZE_BYTE = 3'b000;
    localparam logic [2:0] SIZE_HALF = 3'b001;
    localparam logic [2:0] SIZE_WORD = 3'b010;

    localparam logic RESP_OKAY  = 1'b0;
    localparam logic RESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } slv_state_e;

endpackage

// File: rtl/ahb_lane_dec.sv
// Little-endian byte-lane decode of addr[1:0]/hsize; sizes above word strobe all lanes.
module ahb_lane_dec
    import ahb_pkg::*;
(
    input  logic [1:0] addr,
    input  logic [2:0] size,
    output logic [3:0] strb,
    output logic       misaligned
);

    always_comb begin
        strb       = 4'hF;
        misaligned = 1'b0;
        case (size)
            SIZE_BYTE: strb = 4'b0001 << addr;
            SIZE_HALF: begin
                strb       = addr[1] ? 4'b1100 : 4'b0011;
                misaligned = addr[0];
            end
            SIZE_WORD: misaligned = |addr;
            default:   misaligned = |addr;
        endcase
    end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave with programmable wait states and byte/halfword lanes.
// Define AHB_SLV_ERR_EN to answer misaligned, oversize and out-of-window transfers with ERROR.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic        hready,
    input  logic [31:0] hwdata,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic        hresp
);

    slv_state_e          state, state_nxt;
    logic [3:0]          wcnt, wcnt_nxt;
    logic [ADDR_W+1:0]   addr_q;
    logic [2:0]          size_q;
    logic                write_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [31:0]         mem [2**ADDR_W];
    htrans_e             trans;
    logic                accept, err;
    logic [3:0]          strb;
    logic                misal_unused;

    assign trans  = htrans_e'(htrans);
    assign accept = hsel & hready & ((trans == HTRANS_NONSEQ) | (trans == HTRANS_SEQ));
    assign idx_q  = addr_q[ADDR_W+1:2];

`ifdef AHB_SLV_ERR_EN
    logic [3:0] strb_unused;
    logic       misal_a;

    ahb_lane_dec u_chk (
        .addr       (haddr[1:0]),
        .size       (hsize),
        .strb       (strb_unused),
        .misaligned (misal_a)
    );

    assign err = misal_a | (hsize > SIZE_WORD) | (|haddr[31:ADDR_W+2]);
`else
    // Upper address bits alias into the window when errors are disabled.
    logic unused_hi;
    assign unused_hi = ^haddr[31:ADDR_W+2];
    assign err       = 1'b0;
`endif

    ahb_lane_dec u_lane (
        .addr       (addr_q[1:0]),
        .size       (size_q),
        .strb       (strb),
        .misaligned (misal_unused)
    );

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        case (state)
            ST_WAIT: begin
                if (wcnt == 4'd0) state_nxt = ST_DATA;
                else              wcnt_nxt  = wcnt - 4'd1;
            end
            ST_ERR1: state_nxt = ST_ERR2;
            default: state_nxt = ST_IDLE;
        endcase
        // A new address phase can only be sampled while hready is high, i.e. never mid-wait.
        if (accept) begin
            if (err) begin
                state_nxt = ST_ERR1;
            end else if (WAIT_STATES == 0) begin
                state_nxt = ST_DATA;
            end else begin
                state_nxt = ST_WAIT;
                wcnt_nxt  = 4'(WAIT_STATES - 1);
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state   <= ST_IDLE;
            wcnt    <= '0;
            addr_q  <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
            if (accept) begin
                addr_q  <= haddr[ADDR_W+1:0];
                size_q  <= hsize;
                write_q <= hwrite;
            end
        end
    end

    // Array is deliberately not reset; a reset edge drops any pending write.
    always_ff @(posedge hclk) begin
        if (!hreset && state == ST_DATA && write_q) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) mem[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
        end
    end

    assign hreadyout = !(state == ST_WAIT || state == ST_ERR1);
    assign hrdata    = (state == ST_DATA && !write_q) ? mem[idx_q] : 32'h0;

`ifdef AHB_SLV_ERR_EN
    assign hresp = (state == ST_ERR1 || state == ST_ERR2) ? RESP_ERROR : RESP_OKAY;
`else
    assign hresp = RESP_OKAY;
`endif

endmodule
